// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises the pin reset, holds all domains in reset
// while the clock runs, then releases the domains one after another.
// A soft-reset request restarts the sequence. rst_cause records whether the
// last reset came from the pin (0) or from a soft request (1).
//
// state   | meaning
// HOLD    | all channels asserted, counter counting up from T0
// RELEASE | channels dropping one at a time, lowest index first
// RUN     | every channel released, counter saturated
module reset_sequencer #(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGGER     = 1
) (
  input  logic               clk,
  input  logic               reset_in,
  input  logic               soft_rst_req,
  output logic [NUM_OUT-1:0] reset_out_p,
  output logic [NUM_OUT-1:0] reset_out_n,
  output logic               sys_ready,
  output logic               rst_cause
);

  localparam int CW = $clog2(HOLD_CYCLES + NUM_OUT*STAGGER + 1);
  localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES + (NUM_OUT-1)*STAGGER);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  logic                   soft_hit;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_OUT-1:0]     rst_p_q, rst_p_d;
  logic                   ready_q, ready_d;
  logic                   cause_q, cause_d;

  // Synchroniser input side: shift a constant 1 in behind the pin release.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Synchroniser chain: cleared asynchronously, released synchronously.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  // Soft requests are ignored until the synchroniser has released, so a
  // request overlapping a pin reset leaves the cause as pin.
  assign soft_hit = sync_out & soft_rst_req;

  // State register plus all output flops.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      rst_p_q <= '1;
      ready_q <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_p_q <= rst_p_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  // Next state and counter; the counter is zero on the T0 edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!sync_out || soft_hit) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD, ST_RELEASE: begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_LAST) begin
            state_d = ST_RUN;
          end else if (cnt_d == CNT_HOLD) begin
            state_d = ST_RELEASE;
          end
        end
        ST_RUN: begin
          cnt_d = CNT_LAST;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the next-state values so the outputs sit on flops.
  always_comb begin
    rst_p_d = '1;
    for (int k = 0; k < NUM_OUT; k++) begin
      rst_p_d[k] = (cnt_d < CW'(HOLD_CYCLES + k*STAGGER));
    end
    ready_d = (state_d == ST_RUN);
    cause_d = soft_hit ? 1'b1 : cause_q;
  end

  assign reset_out_p = rst_p_q;
  assign reset_out_n = ~rst_p_q;
  assign sys_ready   = ready_q;
  assign rst_cause   = cause_q;

endmodule
